// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard controller: forwarding-select encoding
// and the destination/source match used by every hazard and bypass check.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_LC   = 2'b11
  } fwd_sel_e;

  // Wide enough for any practical register-file index; callers zero-extend.
  localparam int REG_AW = 8;

  // x0 is hardwired zero, so it never produces a dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for variable-latency long ops: one busy bit per
// architectural register plus a saturating count of ops still in flight.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_OUT  = 4,
  localparam int RAW     = $clog2(NUM_REGS),
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [RAW-1:0]      set_rd,
  input  logic                clr_en,
  input  logic [RAW-1:0]      clr_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic [OW-1:0]       outstanding
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [OW-1:0]       cnt_nxt;

  // Clear first so a same-register issue in the same cycle leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (clr_en && (clr_rd != '0)) busy_nxt[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) busy_nxt[set_rd] = 1'b1;
  end

  always_comb begin
    cnt_nxt = outstanding;
    case ({set_en, clr_en})
      2'b10:   cnt_nxt = (outstanding == OW'(MAX_OUT)) ? outstanding : outstanding + 1'b1;
      2'b01:   cnt_nxt = (outstanding == '0) ? outstanding : outstanding - 1'b1;
      default: cnt_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= cnt_nxt;
    end
  end

  a_issue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_en && !clr_en && (outstanding == OW'(MAX_OUT))));

  a_done_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(clr_en && !set_en && (outstanding == '0)));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the 5-stage RV32 core: load-use, scoreboard RAW/WAW,
// long-op structural and WB-read stalls, branch flushes, EX bypass and stall counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 32,
  localparam int RAW     = $clog2(NUM_REGS),
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RAW-1:0]      d_rs1,
  input  logic [RAW-1:0]      d_rs2,
  input  logic [RAW-1:0]      d_rd,
  input  logic                d_regwren,
  input  logic                d_long,
  input  logic [RAW-1:0]      e_rs1,
  input  logic [RAW-1:0]      e_rs2,
  input  logic [RAW-1:0]      e_rd,
  input  logic                e_memren,
  input  logic                e_long_issue,
  input  logic                e_br_taken,
  input  logic [RAW-1:0]      m_rd,
  input  logic                m_regwren,
  input  logic [RAW-1:0]      w_rd,
  input  logic                w_regwren,
  input  logic                lc_done,
  input  logic [RAW-1:0]      lc_rd,
  input  logic                mem_wait,
  output logic                stall_if,
  output logic                ifid_wren,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                pipe_freeze,
  output logic [1:0]          rs1_sel,
  output logic [1:0]          rs2_sel,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [OW-1:0]       outstanding,
  output logic [CNT_W-1:0]    perf_stall_cnt
);

  logic load_use, raw_sb, waw_sb, struct_hz, wb_read, hz;

  function automatic logic hit(input logic [RAW-1:0] rd, input logic [RAW-1:0] rs);
    return reg_hit(REG_AW'(rd), REG_AW'(rs));
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic [RAW-1:0] rs);
    if (m_regwren && hit(m_rd, rs))      return FWD_MEM;
    else if (w_regwren && hit(w_rd, rs)) return FWD_WB;
    else if (lc_done && hit(lc_rd, rs))  return FWD_LC;
    else                                 return FWD_NONE;
  endfunction

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .MAX_OUT  (MAX_OUT)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (e_long_issue),
    .set_rd      (e_rd),
    .clr_en      (lc_done),
    .clr_rd      (lc_rd),
    .busy        (sb_busy),
    .outstanding (outstanding)
  );

  // A register completing this cycle is not a hazard: the completion bypass supplies it.
  always_comb begin
    load_use  = e_memren && (hit(e_rd, d_rs1) || hit(e_rd, d_rs2));
    raw_sb    = (sb_busy[d_rs1] && !(lc_done && hit(lc_rd, d_rs1))) ||
                (sb_busy[d_rs2] && !(lc_done && hit(lc_rd, d_rs2)));
    waw_sb    = d_regwren && sb_busy[d_rd] && !(lc_done && hit(lc_rd, d_rd));
    struct_hz = d_long && (outstanding == OW'(MAX_OUT)) && !lc_done;
    wb_read   = w_regwren && (hit(w_rd, d_rs1) || hit(w_rd, d_rs2));
    hz        = load_use || raw_sb || waw_sb || struct_hz || wb_read;
  end

  always_comb begin
    stall_if    = hz || mem_wait;
    ifid_wren   = !stall_if;
    ifid_flush  = e_br_taken && !mem_wait;
    idex_flush  = (e_br_taken || hz) && !mem_wait;
    pipe_freeze = mem_wait;
    rs1_sel     = fwd_pick(e_rs1);
    rs2_sel     = fwd_pick(e_rs2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (stall_if && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end

  a_no_issue_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    mem_wait |-> !e_long_issue);

endmodule
